// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared transaction-layer widths and defaults
package tl_pkg;

    localparam int REQUESTER_TAG_WIDTH = 10;
    localparam int NUM_TAGS_DEFAULT    = 32;

endpackage

// File: rtl/tl_tx_tag_lowest_free.sv
// rtl/tl_tx_tag_lowest_free.sv - priority encoder returning the lowest clear bit of a busy map
module tl_tx_tag_lowest_free #(
    parameter int NUM_TAGS = 32,
    parameter int IDX_W    = 10
) (
    input  logic [NUM_TAGS-1:0] busy,
    output logic [IDX_W-1:0]    idx,
    output logic                any_free
);

    // Scan high to low so the last hit, and therefore the winner, is the lowest index.
    always_comb begin
        idx      = '0;
        any_free = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                idx      = IDX_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_tx_tag_allocator.sv
// rtl/tl_tx_tag_allocator.sv - non-posted requester tag pool with lowest-free allocation
module tl_tx_tag_allocator #(
    parameter int REQUESTER_TAG_WIDTH = tl_pkg::REQUESTER_TAG_WIDTH,
    parameter int NUM_TAGS            = tl_pkg::NUM_TAGS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    output logic [REQUESTER_TAG_WIDTH-1:0] alloc_tag,
    input  logic                           cpl_valid,
    input  logic [REQUESTER_TAG_WIDTH-1:0] cpl_tag,
    input  logic                           cpl_last,
    output logic [REQUESTER_TAG_WIDTH-1:0] tx_last_req_tag,
    output logic                           cpl_unexpected,
    output logic [REQUESTER_TAG_WIDTH:0]   outstanding_cnt,
    output logic                           all_idle,
    output logic                           full
);

    localparam int CNT_W = REQUESTER_TAG_WIDTH + 1;

    logic [NUM_TAGS-1:0]            bitmap;
    logic [NUM_TAGS-1:0]            alloc_mask;
    logic [NUM_TAGS-1:0]            rel_mask;
    logic [REQUESTER_TAG_WIDTH-1:0] enc_idx;
    logic                           enc_any_free;
    logic                           alloc_fire;
    logic                           cpl_hit;
    logic                           release_fire;

    tl_tx_tag_lowest_free #(
        .NUM_TAGS (NUM_TAGS),
        .IDX_W    (REQUESTER_TAG_WIDTH)
    ) u_lowest_free (
        .busy     (bitmap),
        .idx      (enc_idx),
        .any_free (enc_any_free)
    );

    assign alloc_ready = enc_any_free;
    assign alloc_tag   = enc_idx;
    assign alloc_fire  = alloc_valid && enc_any_free;

    // Matching by equality against every in-range index makes out-of-range tags miss naturally.
    always_comb begin
        cpl_hit    = 1'b0;
        rel_mask   = '0;
        alloc_mask = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (cpl_tag == REQUESTER_TAG_WIDTH'(i) && bitmap[i]) begin
                cpl_hit = 1'b1;
            end
            rel_mask[i]   = cpl_valid && cpl_last && (cpl_tag == REQUESTER_TAG_WIDTH'(i)) && bitmap[i];
            alloc_mask[i] = alloc_fire && (enc_idx == REQUESTER_TAG_WIDTH'(i));
        end
    end

    assign release_fire = cpl_valid && cpl_last && cpl_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap          <= '0;
            outstanding_cnt <= '0;
            tx_last_req_tag <= '0;
            cpl_unexpected  <= 1'b0;
        end else begin
            // The granted tag is clear and the released tag is set, so the masks never overlap.
            bitmap         <= (bitmap | alloc_mask) & ~rel_mask;
            cpl_unexpected <= cpl_valid && !cpl_hit;
            if (alloc_fire) begin
                tx_last_req_tag <= enc_idx;
            end
            case ({alloc_fire, release_fire})
                2'b10:   outstanding_cnt <= outstanding_cnt + 1'b1;
                2'b01:   outstanding_cnt <= outstanding_cnt - 1'b1;
                default: outstanding_cnt <= outstanding_cnt;
            endcase
        end
    end

    assign full     = (outstanding_cnt == CNT_W'(NUM_TAGS));
    assign all_idle = (outstanding_cnt == '0);

endmodule

// File: tb/tb_tl_tx_tag_allocator.sv
// tb/tb_tl_tx_tag_allocator.sv - directed self-checking bench for the requester tag allocator
module tb_tl_tx_tag_allocator;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         alloc_valid;
    logic         alloc_ready;
    logic [W-1:0] alloc_tag;
    logic         cpl_valid;
    logic [W-1:0] cpl_tag;
    logic         cpl_last;
    logic [W-1:0] tx_last_req_tag;
    logic         cpl_unexpected;
    logic [W:0]   outstanding_cnt;
    logic         all_idle;
    logic         full;

    int vectors     = 0;
    int miscompares = 0;

    tl_tx_tag_allocator #(
        .REQUESTER_TAG_WIDTH (W),
        .NUM_TAGS            (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_tag       (alloc_tag),
        .cpl_valid       (cpl_valid),
        .cpl_tag         (cpl_tag),
        .cpl_last        (cpl_last),
        .tx_last_req_tag (tx_last_req_tag),
        .cpl_unexpected  (cpl_unexpected),
        .outstanding_cnt (outstanding_cnt),
        .all_idle        (all_idle),
        .full            (full)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst         = 1'b1;
        alloc_valid = 1'b1;
        cpl_valid   = 1'b0;
        cpl_tag     = '0;
        cpl_last    = 1'b0;
        tick();
        tick();
        chk("reset_cnt",       32'(outstanding_cnt), 0);
        chk("reset_idle",      32'(all_idle), 1);
        chk("reset_full",      32'(full), 0);
        chk("reset_ready",     32'(alloc_ready), 1);
        chk("reset_alloc_tag", 32'(alloc_tag), 0);
        chk("reset_last_tag",  32'(tx_last_req_tag), 0);
        chk("reset_unexp",     32'(cpl_unexpected), 0);
        rst = 1'b0;

        // Three back-to-back grants
        chk("b2b_tag0", 32'(alloc_tag), 0);
        tick();
        chk("b2b_tag1", 32'(alloc_tag), 1);
        chk("b2b_last0", 32'(tx_last_req_tag), 0);
        tick();
        chk("b2b_tag2", 32'(alloc_tag), 2);
        tick();
        alloc_valid = 1'b0;
        chk("b2b_last2", 32'(tx_last_req_tag), 2);
        chk("b2b_cnt3",  32'(outstanding_cnt), 3);
        chk("b2b_idle",  32'(all_idle), 0);

        // Grant tag 3, then grant 4 while releasing 1 in the same cycle
        alloc_valid = 1'b1;
        tick();
        chk("sim_cnt4_pre", 32'(outstanding_cnt), 4);
        cpl_valid = 1'b1;
        cpl_tag   = 10'd1;
        cpl_last  = 1'b1;
        chk("sim_alloc_tag4", 32'(alloc_tag), 4);
        tick();
        alloc_valid = 1'b0;
        cpl_valid   = 1'b0;
        chk("sim_cnt4",      32'(outstanding_cnt), 4);
        chk("sim_last4",     32'(tx_last_req_tag), 4);
        chk("sim_next_tag1", 32'(alloc_tag), 1);
        chk("sim_unexp",     32'(cpl_unexpected), 0);

        // Partial completions on tag 2 keep it outstanding until the final one
        cpl_valid = 1'b1;
        cpl_tag   = 10'd2;
        cpl_last  = 1'b0;
        tick();
        chk("part1_unexp", 32'(cpl_unexpected), 0);
        chk("part1_cnt",   32'(outstanding_cnt), 4);
        tick();
        chk("part2_unexp", 32'(cpl_unexpected), 0);
        chk("part2_cnt",   32'(outstanding_cnt), 4);
        cpl_last = 1'b1;
        tick();
        cpl_valid = 1'b0;
        chk("part_final_unexp", 32'(cpl_unexpected), 0);
        chk("part_final_cnt",   32'(outstanding_cnt), 3);
        chk("part_final_tag",   32'(alloc_tag), 1);

        // Completion for a tag that is not outstanding, then one out of range
        cpl_valid = 1'b1;
        cpl_tag   = 10'd7;
        cpl_last  = 1'b1;
        tick();
        cpl_valid = 1'b0;
        chk("unexp7_pulse", 32'(cpl_unexpected), 1);
        chk("unexp7_cnt",   32'(outstanding_cnt), 3);
        tick();
        chk("unexp7_drop",  32'(cpl_unexpected), 0);
        cpl_valid = 1'b1;
        cpl_tag   = 10'd40;
        tick();
        cpl_valid = 1'b0;
        chk("unexp40_pulse", 32'(cpl_unexpected), 1);
        tick();
        chk("unexp40_drop", 32'(cpl_unexpected), 0);
        chk("unexp40_cnt",  32'(outstanding_cnt), 3);
        chk("unexp_tag1",   32'(alloc_tag), 1);

        // Fill the whole pool from a clean state
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        alloc_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("fill_tag%0d", i), 32'(alloc_tag), 32'(i));
            tick();
        end
        chk("full_flag",  32'(full), 1);
        chk("full_ready", 32'(alloc_ready), 0);
        chk("full_cnt",   32'(outstanding_cnt), 32);
        chk("full_last",  32'(tx_last_req_tag), 31);
        tick();
        chk("full_hold_cnt",  32'(outstanding_cnt), 32);
        chk("full_hold_last", 32'(tx_last_req_tag), 31);
        alloc_valid = 1'b0;
        cpl_valid   = 1'b1;
        cpl_tag     = 10'd5;
        cpl_last    = 1'b1;
        tick();
        cpl_valid = 1'b0;
        chk("rel5_full",  32'(full), 0);
        chk("rel5_ready", 32'(alloc_ready), 1);
        chk("rel5_tag",   32'(alloc_tag), 5);
        chk("rel5_cnt",   32'(outstanding_cnt), 31);

        // Reset mid-operation discards the outstanding tags
        rst = 1'b1;
        tick();
        rst         = 1'b0;
        alloc_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        alloc_valid = 1'b0;
        chk("pre_rst_cnt", 32'(outstanding_cnt), 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_idle", 32'(all_idle), 1);
        chk("post_rst_cnt",  32'(outstanding_cnt), 0);
        chk("post_rst_tag",  32'(alloc_tag), 0);
        chk("post_rst_last", 32'(tx_last_req_tag), 0);
        cpl_valid = 1'b1;
        cpl_tag   = 10'd3;
        cpl_last  = 1'b1;
        tick();
        cpl_valid = 1'b0;
        chk("post_rst_unexp", 32'(cpl_unexpected), 1);
        chk("post_rst_cnt2",  32'(outstanding_cnt), 0);
        tick();
        chk("post_rst_drop",  32'(cpl_unexpected), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
